hbridge_pwm_sequencer: RTL and testbench

Generates the `Hbridge_pwm` command and the active-low bridge output enable (the `GTS1` line) for the dead-time H-bridge driver. The bridge runs in locked-antiphase mode, so duty 128/256 gives zero mean current. The block ramps the duty from that midpoint toward a commanded target and ramps it back on stop. It also latches hardware fault inputs and tristates the bridge on any fault. It sits between the microcontroller command interface and the bridge driver in the CPLD.

---
 rtl/hbridge_pkg.sv | 32 +++
 rtl/hbridge_pwm_sequencer_if.sv | 18 +
 rtl/fault_sync.sv | 25 ++
 rtl/hbridge_pwm_sequencer.sv | 162 ++++++++++++++++
 tb/tb_hbridge_pwm_sequencer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hbridge_pkg.sv
// hbridge_pkg: shared definitions for the H-bridge PWM sequencer.
//   state_t            : sequencer state encoding (also driven out on the state port)
//   DUTY_MID           : locked-antiphase zero-current duty
//   FLT_*              : bit positions inside fault_code
//   clamp_duty()       : limits a requested duty to [lo, hi]
package hbridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STOP  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [7:0] DUTY_MID = 8'd128;

  localparam int FLT_OVERCURRENT     = 0;
  localparam int FLT_NEG_OVERCURRENT = 1;
  localparam int FLT_TEMPERATURE     = 2;
  localparam int FLT_HARDWARE        = 3;

  function automatic logic [7:0] clamp_duty(input logic [7:0] d,
                                            input logic [7:0] lo,
                                            input logic [7:0] hi);
    logic [7:0] r;
    r = d;
    if (d < lo) r = lo;
    if (d > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/hbridge_pwm_sequencer_if.sv
// hbridge_pwm_sequencer_if: command bus from the microcontroller side.
//   enable      : run request, level
//   cmd_valid   : one-clock strobe qualifying duty_target
//   duty_target : requested duty, 128 = zero mean current
//   fault_clear : level request to leave FAULT
// Handshake: cmd_valid is a strobe without a ready. The sequencer samples
// duty_target on every clock where cmd_valid is high and never stalls the
// master; strobes arriving while in FAULT are dropped.
// Modports: master drives the command, slave (the sequencer) receives it.
interface hbridge_pwm_sequencer_if;
  logic       enable;
  logic       cmd_valid;
  logic [7:0] duty_target;
  logic       fault_clear;

  modport master (output enable, output cmd_valid, output duty_target, output fault_clear);
  modport slave  (input  enable, input  cmd_valid, input  duty_target, input  fault_clear);
endinterface

// File: rtl/fault_sync.sv
// fault_sync: 4-bit two-flop synchronizer for the active-low fault inputs.
//   clk      : sampling clock
//   rst_n    : asynchronous active-low reset, outputs return to 4'b1111 (no fault)
//   async_in : raw asynchronous inputs (low = fault)
//   sync_out : synchronized copy, two clocks of latency
module fault_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] async_in,
  output logic [3:0] sync_out
);

  logic [3:0] stage1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1   <= 4'b1111;
      sync_out <= 4'b1111;
    end else begin
      stage1   <= async_in;
      sync_out <= stage1;
    end
  end

endmodule

// File: rtl/hbridge_pwm_sequencer.sv
// hbridge_pwm_sequencer: locked-antiphase PWM generator with duty ramping and
// fault latching for the dead-time H-bridge driver.
//   GCK1            : system clock, rising edge
//   GSR1            : asynchronous active-low reset
//   cmd             : command bus (enable, cmd_valid, duty_target, fault_clear)
//   no*/heatsink*   : asynchronous fault inputs, low = fault
//   Hbridge_pwm     : registered PWM, high while cnt < duty_cur
//   bridge_enable_n : GTS1, low = bridge driven
//   fault_code      : sticky fault bits (see FLT_* in hbridge_pkg)
//   state           : sequencer state (IDLE/RUN/STOP/FAULT)
//   at_target       : RUN and the ramp has reached the commanded duty
module hbridge_pwm_sequencer
  import hbridge_pkg::*;
#(
  parameter int PRESCALE     = 4,
  parameter int RAMP_PERIODS = 2,
  parameter int DUTY_MIN     = 8,
  parameter int DUTY_MAX     = 248
) (
  input  logic                          GCK1,
  input  logic                          GSR1,
  hbridge_pwm_sequencer_if.slave        cmd,
  input  logic                          noOvercurrent,
  input  logic                          noNegativeOvercurrent,
  input  logic                          heatsinkTempOk,
  input  logic                          noHardwareError,
  output logic                          Hbridge_pwm,
  output logic                          bridge_enable_n,
  output logic [3:0]                    fault_code,
  output logic [1:0]                    state,
  output logic                          at_target
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

  // ---------------------------------------------------------------- faults
  logic [3:0] ok_raw;
  logic [3:0] ok_sync;
  logic [3:0] fault_bits;
  logic       fault_any;

  always_comb begin
    ok_raw                      = 4'b1111;
    ok_raw[FLT_OVERCURRENT]     = noOvercurrent;
    ok_raw[FLT_NEG_OVERCURRENT] = noNegativeOvercurrent;
    ok_raw[FLT_TEMPERATURE]     = heatsinkTempOk;
    ok_raw[FLT_HARDWARE]        = noHardwareError;
  end

  fault_sync u_fault_sync (
    .clk      (GCK1),
    .rst_n    (GSR1),
    .async_in (ok_raw),
    .sync_out (ok_sync)
  );

  assign fault_bits = ~ok_sync;
  assign fault_any  = |fault_bits;

  // ------------------------------------------------------- PWM time base
  logic [PW-1:0] presc;
  logic [7:0]    cnt;
  logic          tick;
  logic          wrap;

  assign tick = (presc == PW'(PRESCALE - 1));
  assign wrap = tick && (cnt == 8'd255);

  // ------------------------------------------------------------------ FSM
  state_t state_q;
  state_t state_d;

  logic [7:0]    duty_cur;
  logic [7:0]    duty_tgt;
  logic [RW-1:0] ramp_cnt;

  always_comb begin
    state_d = state_q;
    if (fault_any) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE:  if (wrap && cmd.enable) state_d = ST_RUN;
        ST_RUN:   if (!cmd.enable) state_d = ST_STOP;
        // Re-enabling during the ramp-down wins over reaching the midpoint.
        ST_STOP: begin
          if (cmd.enable)              state_d = ST_RUN;
          else if (duty_cur == DUTY_MID) state_d = ST_IDLE;
        end
        ST_FAULT: if (cmd.fault_clear) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge GCK1 or negedge GSR1) begin
    if (!GSR1) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ------------------------------------------------------------- datapath
  logic       fault_exit;
  logic       ramping;
  logic       ramp_step;
  logic [7:0] ramp_goal;

  assign fault_exit = (state_q == ST_FAULT) && cmd.fault_clear && !fault_any;
  assign ramping    = (state_q == ST_RUN) || (state_q == ST_STOP);
  assign ramp_goal  = (state_q == ST_RUN) ? duty_tgt : DUTY_MID;
  // The ramp phase restarts at zero on every entry into RUN from IDLE, so the
  // first step lands RAMP_PERIODS wraps after entry.
  assign ramp_step  = ramping && wrap && (ramp_cnt == RW'(RAMP_PERIODS - 1));

  always_ff @(posedge GCK1 or negedge GSR1) begin
    if (!GSR1) begin
      presc       <= '0;
      cnt         <= 8'd0;
      Hbridge_pwm <= 1'b0;
      duty_cur    <= DUTY_MID;
      duty_tgt    <= DUTY_MID;
      ramp_cnt    <= '0;
      fault_code  <= 4'd0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) cnt <= cnt + 8'd1;

      Hbridge_pwm <= (cnt < duty_cur);

      if (fault_exit) begin
        fault_code <= 4'd0;
        duty_cur   <= DUTY_MID;
        duty_tgt   <= DUTY_MID;
        ramp_cnt   <= '0;
      end else begin
        // Accumulating in every state also catches a single-clock fault pulse
        // that is already gone by the time the FSM reaches FAULT.
        fault_code <= fault_code | fault_bits;

        if (cmd.cmd_valid && (state_q != ST_FAULT))
          duty_tgt <= clamp_duty(cmd.duty_target, 8'(DUTY_MIN), 8'(DUTY_MAX));

        if (!ramping)
          ramp_cnt <= '0;
        else if (wrap)
          ramp_cnt <= (ramp_cnt == RW'(RAMP_PERIODS - 1)) ? '0 : ramp_cnt + 1'b1;

        // Only on wrap, so a PWM period never mixes two duty values.
        if (ramp_step) begin
          if (duty_cur < ramp_goal)      duty_cur <= duty_cur + 8'd1;
          else if (duty_cur > ramp_goal) duty_cur <= duty_cur - 8'd1;
        end
      end
    end
  end

  // -------------------------------------------------------------- outputs
  assign state           = state_q;
  assign bridge_enable_n = !ramping;
  assign at_target       = (state_q == ST_RUN) && (duty_cur == duty_tgt);

endmodule

// File: tb/tb_hbridge_pwm_sequencer.sv
module tb_hbridge_pwm_sequencer;

  localparam int P      = 2;
  localparam int RP     = 2;
  localparam int DMIN   = 120;
  localparam int DMAX   = 136;
  localparam int PERIOD = 256 * P;

  // ------------------------------------------------ clock / reset / wiring
  logic clk  = 1'b0;
  logic GSR1 = 1'b0;
  always #5 clk = ~clk;

  hbridge_pwm_sequencer_if cmd_if ();

  logic       noOvercurrent         = 1'b1;
  logic       noNegativeOvercurrent = 1'b1;
  logic       heatsinkTempOk        = 1'b1;
  logic       noHardwareError       = 1'b1;
  logic       Hbridge_pwm;
  logic       bridge_enable_n;
  logic [3:0] fault_code;
  logic [1:0] state;
  logic       at_target;

  hbridge_pwm_sequencer #(
    .PRESCALE     (P),
    .RAMP_PERIODS (RP),
    .DUTY_MIN     (DMIN),
    .DUTY_MAX     (DMAX)
  ) dut (
    .GCK1                  (clk),
    .GSR1                  (GSR1),
    .cmd                   (cmd_if),
    .noOvercurrent         (noOvercurrent),
    .noNegativeOvercurrent (noNegativeOvercurrent),
    .heatsinkTempOk        (heatsinkTempOk),
    .noHardwareError       (noHardwareError),
    .Hbridge_pwm           (Hbridge_pwm),
    .bridge_enable_n       (bridge_enable_n),
    .fault_code            (fault_code),
    .state                 (state),
    .at_target             (at_target)
  );

  // ------------------------------------------------------------ scoreboard
  int n_compared = 0;
  int n_mismatch = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatch++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  // ------------------------------------------------------ behavioural model
  // Time base from absolute clock count; fault path as a two-deep delay line.
  int unsigned m_clocks = 0;
  logic [3:0]  m_ok1 = 4'hF, m_ok2 = 4'hF, m_code = 4'h0, x_code;
  int          m_state = 0, m_cur = 128, m_tgt = 128, m_wraps = 0;
  logic        m_pwm = 1'b0;
  int          x_cnt, x_state, x_cur, x_tgt, x_wraps, x_goal;
  bit          x_wrap, x_fault;

  function automatic int clamp_m(input int d);
    if (d < DMIN) return DMIN;
    if (d > DMAX) return DMAX;
    return d;
  endfunction

  always @(posedge clk or negedge GSR1) begin
    if (!GSR1) begin
      m_clocks = 0; m_ok1 = 4'hF; m_ok2 = 4'hF; m_code = 4'h0;
      m_state = 0; m_cur = 128; m_tgt = 128; m_wraps = 0; m_pwm = 1'b0;
    end else begin
      x_cnt   = int'((m_clocks / P) % 256);
      x_wrap  = ((m_clocks % P) == P - 1) && (x_cnt == 255);
      x_fault = (m_ok2 != 4'hF);
      x_state = m_state;
      if (x_fault) x_state = 3;
      else if (m_state == 0 && x_wrap && cmd_if.enable) x_state = 1;
      else if (m_state == 1 && !cmd_if.enable) x_state = 2;
      else if (m_state == 2 && cmd_if.enable) x_state = 1;
      else if (m_state == 2 && m_cur == 128) x_state = 0;
      else if (m_state == 3 && cmd_if.fault_clear) x_state = 0;

      x_cur = m_cur; x_tgt = m_tgt; x_wraps = m_wraps; x_code = m_code | ~m_ok2;
      if (m_state == 3 && x_state == 0) begin
        x_cur = 128; x_tgt = 128; x_wraps = 0; x_code = 4'h0;
      end else begin
        if (m_state != 3 && cmd_if.cmd_valid) x_tgt = clamp_m(int'(cmd_if.duty_target));
        if (m_state == 1 || m_state == 2) begin
          if (x_wrap) begin
            x_wraps = m_wraps + 1;
            if (x_wraps % RP == 0) begin
              x_goal = (m_state == 1) ? m_tgt : 128;
              if (m_cur < x_goal) x_cur = m_cur + 1;
              else if (m_cur > x_goal) x_cur = m_cur - 1;
            end
          end
        end else begin
          x_wraps = 0;
        end
      end

      m_pwm   = (x_cnt < m_cur);
      m_ok2   = m_ok1;
      m_ok1   = {noHardwareError, heatsinkTempOk, noNegativeOvercurrent, noOvercurrent};
      m_state = x_state; m_cur = x_cur; m_tgt = x_tgt; m_wraps = x_wraps; m_code = x_code;
      m_clocks++;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("pwm",       int'(Hbridge_pwm),     int'(m_pwm));
    check("bridge_en_n", int'(bridge_enable_n), (m_state == 1 || m_state == 2) ? 0 : 1);
    check("fault_code", int'(fault_code),     int'(m_code));
    check("state",     int'(state),           m_state);
    check("at_target", int'(at_target),       (m_state == 1 && m_cur == m_tgt) ? 1 : 0);
  end

  // ---------------------------------------------------------- driver tasks
  task automatic send_cmd(input logic [7:0] d);
    @(negedge clk);
    cmd_if.cmd_valid   = 1'b1;
    cmd_if.duty_target = d;
    @(negedge clk);
    cmd_if.cmd_valid   = 1'b0;
  endtask

  task automatic wait_state(input string name, input int s, input int max_cycles);
    int n;
    n = 0;
    while (int'(state) != s && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(state), s);
  endtask

  task automatic wait_at_target(input string name, input int max_cycles);
    int n;
    n = 0;
    while (!at_target && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(at_target), 1);
  endtask

  task automatic measure_high(input string name, input int expected);
    int hi;
    hi = 0;
    repeat (PERIOD) begin
      @(negedge clk);
      if (Hbridge_pwm) hi++;
    end
    check(name, hi, expected);
  endtask

  // -------------------------------------------------------------- stimulus
  int       flt_len = 0;
  int       flt_bit = 0;
  logic [3:0] ok_vec;

  initial begin
    cmd_if.enable      = 1'b0;
    cmd_if.cmd_valid   = 1'b0;
    cmd_if.duty_target = 8'd128;
    cmd_if.fault_clear = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pwm",  int'(Hbridge_pwm), 0);
    check("rst_be_n", int'(bridge_enable_n), 1);
    check("rst_code", int'(fault_code), 0);
    check("rst_state", int'(state), 0);
    check("rst_at_target", int'(at_target), 0);
    GSR1 = 1'b1;

    // IDLE: 50% locked-antiphase, bridge tristated
    measure_high("idle_high", 128 * P);
    check("idle_state", int'(state), 0);
    check("idle_be_n", int'(bridge_enable_n), 1);

    // RUN with an over-range target clamps to DMAX
    cmd_if.enable = 1'b1;
    send_cmd(8'd255);
    wait_state("enter_run", 1, 2 * PERIOD + 4);
    check("run_be_n", int'(bridge_enable_n), 0);
    wait_at_target("reach_max", (DMAX - 128) * RP * PERIOD + 2 * PERIOD);
    measure_high("run_high_max", DMAX * P);

    // Under-range target clamps to DMIN
    send_cmd(8'd0);
    check("at_target_drop", int'(at_target), 0);
    wait_at_target("reach_min", (DMAX - DMIN) * RP * PERIOD + 2 * PERIOD);
    measure_high("run_high_min", DMIN * P);

    // Single-clock overcurrent pulse during RUN
    @(negedge clk) noOvercurrent = 1'b0;
    @(negedge clk) noOvercurrent = 1'b1;
    repeat (2) @(negedge clk);
    check("flt_be_n_3clk", int'(bridge_enable_n), 1);
    check("flt_state", int'(state), 3);
    check("flt_code_oc", int'(fault_code), 4'b0001);

    // Clear refused while the temperature fault persists
    heatsinkTempOk = 1'b0;
    cmd_if.enable  = 1'b0;
    repeat (3) @(negedge clk);
    cmd_if.fault_clear = 1'b1;
    repeat (4) @(negedge clk);
    check("hold_state", int'(state), 3);
    check("hold_code", int'(fault_code), 4'b0101);
    heatsinkTempOk = 1'b1;
    repeat (4) @(negedge clk);
    check("clear_state", int'(state), 0);
    check("clear_code", int'(fault_code), 0);
    check("clear_be_n", int'(bridge_enable_n), 1);
    cmd_if.fault_clear = 1'b0;

    // RUN up, then drop enable: STOP ramps back to 128, then IDLE
    cmd_if.enable = 1'b1;
    send_cmd(8'd140);
    wait_state("rerun", 1, 2 * PERIOD + 4);
    wait_at_target("reach_136", (DMAX - 128) * RP * PERIOD + 2 * PERIOD);
    @(negedge clk) cmd_if.enable = 1'b0;
    @(negedge clk);
    check("stop_state", int'(state), 2);
    check("stop_be_n", int'(bridge_enable_n), 0);
    wait_state("stop_to_idle", 0, (DMAX - 128) * RP * PERIOD + 2 * PERIOD);
    check("idle_after_stop_be_n", int'(bridge_enable_n), 1);

    // Randomized traffic, per-cycle model comparison does the checking
    cmd_if.enable = 1'b1;
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      cmd_if.duty_target = 8'($urandom_range(0, 255));
      if (m_clocks % PERIOD == PERIOD - 1)
        cmd_if.cmd_valid = ($urandom_range(0, 1) == 0);
      else
        cmd_if.cmd_valid = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7999) == 0) cmd_if.enable = ~cmd_if.enable;
      cmd_if.fault_clear = ($urandom_range(0, 63) == 0);
      if (flt_len == 0 && $urandom_range(0, 4999) == 0) begin
        flt_len = int'($urandom_range(1, 3));
        flt_bit = int'($urandom_range(0, 3));
      end
      ok_vec = 4'hF;
      if (flt_len > 0) begin
        ok_vec[flt_bit] = 1'b0;
        flt_len--;
      end
      {noHardwareError, heatsinkTempOk, noNegativeOvercurrent, noOvercurrent} = ok_vec;
    end

    // Back to a clean RUN, then asynchronous reset mid-RUN
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    {noHardwareError, heatsinkTempOk, noNegativeOvercurrent, noOvercurrent} = 4'hF;
    cmd_if.fault_clear = 1'b1;
    repeat (5) @(negedge clk);
    cmd_if.fault_clear = 1'b0;
    cmd_if.enable = 1'b1;
    send_cmd(8'd255);
    wait_state("final_run", 1, 2 * PERIOD + 4);
    wait_at_target("final_target", (DMAX - DMIN) * RP * PERIOD + 2 * PERIOD);
    for (int n = 0; n < PERIOD && !Hbridge_pwm; n++) @(negedge clk);
    check("pre_reset_pwm", int'(Hbridge_pwm), 1);
    #2 GSR1 = 1'b0;
    #1;
    check("async_rst_pwm", int'(Hbridge_pwm), 0);
    check("async_rst_be_n", int'(bridge_enable_n), 1);
    check("async_rst_code", int'(fault_code), 0);
    check("async_rst_state", int'(state), 0);
    check("async_rst_at_target", int'(at_target), 0);
    @(negedge clk) GSR1 = 1'b1;
    repeat (2 * PERIOD) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
